// File: rtl/ifm_pkg.sv
// Shared types and helpers for the IFM feeder slice (state encoding, byte width, beat math).
package ifm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } feeder_state_t;

    localparam int BYTE_W = 8;

    function automatic int beats_per_vec(input int col, input int in_bytes);
        return col / in_bytes;
    endfunction

endpackage

// File: rtl/ifm_packer.sv
// Packs IN_BYTES-wide beats into one COL-byte vector; holds it (pack_full) until the staging
// register takes it via xfer.
module ifm_packer
    import ifm_pkg::*;
#(
    parameter int COL      = 8,
    parameter int IN_BYTES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      allow,
    input  logic [IN_BYTES*8-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      xfer,
    output logic [COL*8-1:0]          pack_data,
    output logic                      pack_full
);

    localparam int BEATS  = beats_per_vec(COL, IN_BYTES);
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = IN_BYTES * BYTE_W;

    logic [BW-1:0] beat_idx;
    logic          accept;
    logic          last_beat;

    assign in_ready  = allow && !pack_full;
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_idx == BW'(BEATS - 1));

    // NOTE: every register here is written with <= so all of them see the pre-edge beat_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_data <= '0;
            beat_idx  <= '0;
            pack_full <= 1'b0;
        end else if (clr) begin
            beat_idx  <= '0;
            pack_full <= 1'b0;
        end else begin
            if (accept) begin
                pack_data[beat_idx*BEAT_W +: BEAT_W] <= in_data;
                if (last_beat) begin
                    beat_idx  <= '0;
                    pack_full <= 1'b1;
                end else begin
                    beat_idx <= beat_idx + BW'(1);
                end
            end
            // accept needs !pack_full and xfer needs pack_full, so the two never collide.
            if (xfer) begin
                pack_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ifm_feeder.sv
// IFM feeder top: tile FSM, staging register and vector counters around ifm_packer.
// Optional starvation counter output stall_cnt is enabled by defining IFM_STALL_CNT_EN.
module ifm_feeder
    import ifm_pkg::*;
#(
    parameter int COL      = 8,
    parameter int IN_BYTES = 2,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      tile_len,
    input  logic [IN_BYTES*8-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  step,
    output logic [COL*8-1:0]      ifm_out,
    output logic                  ifm_read,
    output logic                  busy,
    output logic                  done
`ifdef IFM_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int BEATS = beats_per_vec(COL, IN_BYTES);
    localparam int TOT_W = CNT_W + $clog2(BEATS);

    feeder_state_t      state, state_nxt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   issued;
    logic [TOT_W-1:0]   beats_acc;
    logic [TOT_W-1:0]   beats_total;
    logic [COL*8-1:0]   stg;
    logic               stg_vld;
    logic [COL*8-1:0]   pack_data;
    logic               pack_full;
    logic               start_ok;
    logic               allow;
    logic               accept;
    logic               fire;
    logic               xfer;

    assign start_ok    = (state == IDLE) && start;
    assign beats_total = TOT_W'(len_q) * TOT_W'(BEATS);
    assign allow       = (state == RUN) && (beats_acc < beats_total);
    assign accept      = in_valid && in_ready;
    assign fire        = (state == RUN) && stg_vld && step;
    assign xfer        = (state == RUN) && pack_full && (!stg_vld || fire);

    assign ifm_out  = stg;
    assign ifm_read = fire;
    assign busy     = (state == RUN);
    assign done     = (state == FIN);

    ifm_packer #(
        .COL      (COL),
        .IN_BYTES (IN_BYTES)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .allow     (allow),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xfer      (xfer),
        .pack_data (pack_data),
        .pack_full (pack_full)
    );

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (tile_len != '0) ? RUN : FIN;
            RUN:  if (fire && (issued + CNT_W'(1) == len_q)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            issued    <= '0;
            beats_acc <= '0;
            stg       <= '0;
            stg_vld   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                if (tile_len != '0) len_q <= tile_len;
                issued    <= '0;
                beats_acc <= '0;
            end
            if (accept) beats_acc <= beats_acc + TOT_W'(1);
            if (fire)   issued    <= issued + CNT_W'(1);
            // A fire with a simultaneous xfer keeps stg_vld high: back-to-back vectors.
            if (xfer) begin
                stg     <= pack_data;
                stg_vld <= 1'b1;
            end else if (fire) begin
                stg_vld <= 1'b0;
            end
        end
    end

`ifdef IFM_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && step && !stg_vld && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifm_feeder.sv
// Randomized self-checking bench for ifm_feeder against a count-based transaction model.
module tb_ifm_feeder;

    localparam int COL      = 8;
    localparam int IN_BYTES = 2;
    localparam int CNT_W    = 16;
    localparam int BEATS    = COL / IN_BYTES;
    localparam int IW       = IN_BYTES * 8;
    localparam int OW       = COL * 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] tile_len = '0;
    logic [IW-1:0]    in_data = '0;
    logic             in_valid = 1'b0;
    logic             step = 1'b0;
    logic             in_ready;
    logic [OW-1:0]    ifm_out;
    logic             ifm_read;
    logic             busy;
    logic             done;
`ifdef IFM_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    ifm_feeder #(
        .COL      (COL),
        .IN_BYTES (IN_BYTES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tile_len (tile_len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .step     (step),
        .ifm_out  (ifm_out),
        .ifm_read (ifm_read),
        .busy     (busy),
        .done     (done)
`ifdef IFM_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tile progress tracked as plain counts of beats, completed vectors,
    // vectors moved to staging and vectors issued.
    typedef enum int {M_IDLE, M_RUN, M_FIN} mstate_t;

    mstate_t     m_state = M_IDLE;
    bit          m_live  = 1'b0;
    int          m_len, m_beats, m_vdone, m_moved, m_iss;
    longint      m_stall;
    logic [63:0] m_vec [64];
    logic [63:0] m_last;

    // Observed-event statistics for the directed scenarios.
    int          cyc = 0;
    int          dut_beats, n_reads, n_done;
    int          last_beat_cyc, read0_cyc, read1_cyc, done_cyc;
    logic [63:0] dut_last_read;

    logic        exp_rdy, exp_fire, m_stg, m_xfer;

    always @(negedge clk) begin
        cyc++;
        m_stg    = (m_moved > m_iss);
        exp_rdy  = (m_state == M_RUN) && (m_vdone == m_moved) && (m_beats < m_len * BEATS);
        exp_fire = (m_state == M_RUN) && m_stg && step;
        if (m_live) begin
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("ifm_read", 64'(ifm_read), 64'(exp_fire));
            check("busy", 64'(busy), 64'(m_state == M_RUN));
            check("done", 64'(done), 64'(m_state == M_FIN));
            if (exp_fire) check("ifm_out", ifm_out, m_vec[m_iss % 64]);
            if (m_state == M_IDLE) check("ifm_out_hold", ifm_out, m_last);
`ifdef IFM_STALL_CNT_EN
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
            if (in_valid && in_ready) begin
                dut_beats++;
                if (dut_beats % BEATS == 0) last_beat_cyc = cyc;
            end
            if (ifm_read) begin
                if (n_reads == 0) read0_cyc = cyc;
                if (n_reads == 1) read1_cyc = cyc;
                n_reads++;
                dut_last_read = ifm_out;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        if (rst) begin
            m_live  = 1'b1;
            m_state = M_IDLE;
            m_len   = 0; m_beats = 0; m_vdone = 0; m_moved = 0; m_iss = 0;
            m_stall = 0;
            m_last  = '0;
        end else if (m_live) begin
            case (m_state)
                M_IDLE: if (start) begin
                    m_len   = int'(tile_len);
                    m_beats = 0; m_vdone = 0; m_moved = 0; m_iss = 0;
                    m_stall = 0;
                    m_state = (tile_len != 0) ? M_RUN : M_FIN;
                end
                M_RUN: begin
                    m_xfer = (m_vdone > m_moved) && (!m_stg || exp_fire);
                    if (step && !m_stg && m_stall < 64'hFFFF_FFFF) m_stall++;
                    if (m_xfer) m_moved++;
                    if (exp_fire) begin
                        m_last = m_vec[m_iss % 64];
                        m_iss++;
                        if (m_iss == m_len) m_state = M_FIN;
                    end
                    if (exp_rdy && in_valid) begin
                        m_vec[(m_beats / BEATS) % 64][(m_beats % BEATS)*IW +: IW] = in_data;
                        m_beats++;
                        if (m_beats % BEATS == 0) m_vdone++;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        dut_beats = 0; n_reads = 0; n_done = 0;
        last_beat_cyc = 0; read0_cyc = 0; read1_cyc = 0; done_cyc = 0;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        tile_len = CNT_W'(len);
        in_valid = 1'b0;
        step     = 1'b0;
        tick();
        start    = 1'b0;
    endtask

    // vpat: 0 = in_valid always, 1 = alternating, else random. Stray starts test that RUN ignores them.
    task automatic drive_cycle(input int vpat, input int sprob, input bit directed, input bit noise);
        case (vpat)
            0:       in_valid = 1'b1;
            1:       in_valid = ~in_valid;
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        step     = ($urandom_range(1, 100) <= sprob);
        in_data  = directed ? {8'(2*m_beats + 2), 8'(2*m_beats + 1)} : IW'($urandom);
        start    = noise && ($urandom_range(0, 7) == 0);
        tile_len = CNT_W'($urandom_range(0, 5));
        tick();
    endtask

    task automatic finish_tile(input int vpat, input int sprob, input bit directed, input bit noise);
        for (int n = 0; n < 2000 && m_state != M_IDLE; n++) drive_cycle(vpat, sprob, directed, noise);
        start    = 1'b0;
        in_valid = 1'b0;
        step     = 1'b0;
        check("tile_end_busy", 64'(busy), 64'(0));
    endtask

    task automatic run_tile(input int len, input int vpat, input int sprob, input bit directed);
        do_start(len);
        finish_tile(vpat, sprob, directed, 1'b1);
    endtask

    initial begin
        clear_stats();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Basic tile: one vector, data and latency.
        clear_stats();
        run_tile(1, 0, 100, 1'b1);
        repeat (2) tick();
        check("s1_vector", dut_last_read, 64'h0807_0605_0403_0201);
        check("s1_reads", 64'(n_reads), 64'(1));
        check("s1_latency", 64'(read0_cyc - last_beat_cyc), 64'(2));
        check("s1_done_delay", 64'(done_cyc - read0_cyc), 64'(1));

        // Backpressure: step low, both buffers fill and input stalls.
        clear_stats();
        do_start(3);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            step     = 1'b0;
            in_data  = IW'($urandom);
            tick();
        end
        check("s2_beats", 64'(dut_beats), 64'(2 * BEATS));
        check("s2_reads", 64'(n_reads), 64'(0));
        check("s2_stg_vld", 64'(dut.stg_vld), 64'(1));
        check("s2_pack_full", 64'(dut.u_packer.pack_full), 64'(1));

        // Release: back-to-back reads, third vector follows.
        finish_tile(0, 100, 1'b0, 1'b0);
        repeat (2) tick();
        check("s3_reads", 64'(n_reads), 64'(3));
        check("s3_back2back", 64'(read1_cyc - read0_cyc), 64'(1));
        check("s3_done", 64'(n_done), 64'(1));

        // Zero-length tile.
        clear_stats();
        do_start(0);
        repeat (3) tick();
        check("s4_done", 64'(n_done), 64'(1));
        check("s4_reads", 64'(n_reads), 64'(0));
        check("s4_beats", 64'(dut_beats), 64'(0));

        // Reset mid-tile, then a fresh tile.
        clear_stats();
        do_start(2);
        for (int n = 0; n < 100 && m_beats < 5; n++) drive_cycle(0, 0, 1'b0, 1'b0);
        check("s5_beats_before_rst", 64'(m_beats), 64'(5));
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        check("s5_no_done", 64'(n_done), 64'(0));
        check("s5_ifm_out", ifm_out, 64'(0));
        run_tile(2, 0, 100, 1'b0);

        // Starvation: step high with gapped input.
        run_tile(3, 1, 100, 1'b0);
        run_tile(2, 1, 100, 1'b0);

        // Random tiles with random valid/step density.
        for (int t = 0; t < 10; t++) begin
            run_tile($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(10, 100), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
